reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 5, register index width (32 registers).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: freeze  input  1  pipeline freeze; blocks acceptance from both requesters.
REQ-006 Port: alu_valid / alu_rd / alu_data  input  1 / ADDR_W / DATA_W  requester 0 (ALU writeback) write request.
REQ-007 Port: alu_ready  output  1  requester 0 accepted this cycle.
REQ-008 Port: lsu_valid / lsu_rd / lsu_data  input  1 / ADDR_W / DATA_W  requester 1 (load unit) write request.
REQ-009 Port: lsu_ready  output  1  requester 1 accepted this cycle.
REQ-010 Port: regwrite / write_reg / write_data  output  1 / ADDR_W / DATA_W  registered drive of the reg_file write port.
REQ-011 Port: read_reg1 / read_reg2  input  ADDR_W each  indices currently presented to reg_file read ports.
REQ-012 Port: fwd1_hit / fwd1_data, fwd2_hit / fwd2_data  output  1 / DATA_W each  bypass for in-flight write.
REQ-013 Port: conflict_cnt  output  16  saturating count of contended cycles.

Function
REQ-014 Transfer on requester k SHALL occur when k_valid && k_ready in the same cycle; ready SHALL be combinational from valid, freeze and the round-robin pointer.
REQ-015 freeze=1 SHALL force alu_ready=lsu_ready=0; the output stage SHALL load regwrite=0 on that edge.
REQ-016 freeze=0, exactly one valid: that requester SHALL get ready=1; pointer unchanged.
REQ-017 freeze=0, both valid: grant SHALL go to the requester not granted in the last contended cycle (rr_ptr); after the grant rr_ptr SHALL point to the loser; the loser SHALL see ready=0 and must hold its request.
REQ-018 rr_ptr after reset SHALL favour requester 1 (LSU) at the first contention.
REQ-019 Neither valid: ready outputs 0; output stage loads regwrite=0.
REQ-020 Output stage: on the edge completing a transfer, write_reg<=rd, write_data<=data, regwrite<=(rd!=0); latency exactly one cycle from acceptance to regwrite high.
REQ-021 rd==0: request SHALL still be accepted (ready per normal rules), regwrite SHALL stay 0, rr_ptr SHALL update as for any grant.
REQ-022 When regwrite=0, write_reg and write_data SHALL hold their previous values.
REQ-023 Sustained throughput: one write per cycle with no bubble when requests are back-to-back.
REQ-024 fwdN_hit SHALL be combinational: regwrite && (read_regN==write_reg) && (write_reg!=0); fwdN_data=write_data when hit, else 0.
REQ-025 conflict_cnt SHALL increment by 1 on every edge where alu_valid && lsu_valid && !freeze; it SHALL saturate at 16'hFFFF (no wrap).
REQ-026 Valid dropped without ready (protocol violation) SHALL have no effect on state.

Reset
REQ-027 rst_n low SHALL immediately, regardless of clk: regwrite=0, write_reg=0, write_data=0, rr_ptr=LSU-first, conflict_cnt=0.
REQ-028 While rst_n low, alu_ready=lsu_ready=0 and fwd1_hit=fwd2_hit=0.
REQ-029 Reset asserted mid-transfer SHALL discard the accepted-but-unwritten request; no regwrite pulse after release until a new transfer.
REQ-030 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Single ALU req rd=3, data=32'h1111 -> alu_ready=1 same cycle; next cycle regwrite=1, write_reg=3, write_data=32'h1111.
REQ-032 Both valid for 4 cycles (alu rd=1, lsu rd=2) -> grants LSU, ALU, LSU, ALU; conflict_cnt=4; regwrite every cycle.
REQ-033 LSU req rd=0, data=32'hDEAD -> lsu_ready=1, regwrite stays 0, fwd hits 0.
REQ-034 ALU writes rd=5, data=32'h2222, read_reg1=5 during output cycle -> fwd1_hit=1, fwd1_data=32'h2222; read_reg2=6 -> fwd2_hit=0.
REQ-035 freeze=1 with both valid -> both ready 0, regwrite 0, conflict_cnt unchanged; freeze release -> normal grant next cycle.
REQ-036 rst_n pulsed low between clock edges right after an acceptance -> outputs zero asynchronously, no write appears after release; conflict_cnt preset to 16'hFFFE then 3 contended cycles -> holds 16'hFFFF.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter merging ALU and load-unit writebacks onto the single
// reg_file write port, with a one-entry bypass and a contention counter.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              regwrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_LSU = 1'b1
  } rr_ptr_t;

  rr_ptr_t           rr_ptr;
  logic              contend;
  logic              accept;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign contend = alu_valid && lsu_valid && !freeze;

  // Ready is gated by rst_n so nothing is acknowledged while held in reset.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst_n && !freeze) begin
      if (contend) begin
        alu_ready = (rr_ptr == PTR_ALU);
        lsu_ready = (rr_ptr == PTR_LSU);
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  always_comb begin
    accept   = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_valid && alu_ready) begin
      accept   = 1'b1;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (lsu_valid && lsu_ready) begin
      accept   = 1'b1;
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
  end

  // Writes to r0 are accepted but leave the write port registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      regwrite <= accept && (sel_rd != '0);
      if (accept && (sel_rd != '0)) begin
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= PTR_LSU;
      conflict_cnt <= '0;
    end else if (contend) begin
      rr_ptr <= (rr_ptr == PTR_LSU) ? PTR_ALU : PTR_LSU;
      if (conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    fwd1_hit  = rst_n && regwrite && (read_reg1 == write_reg) && (write_reg != '0);
    fwd2_hit  = rst_n && regwrite && (read_reg2 == write_reg) && (write_reg != '0);
    fwd1_data = fwd1_hit ? write_data : '0;
    fwd2_data = fwd2_hit ? write_data : '0;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed plus randomized bench for reg_write_arbiter against a behavioural
// model of grants, the registered write port, bypass and contention count.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: who wins the next contention, the last committed write and
  // the number of contended cycles seen since reset.
  bit          m_lsu_first;
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int unsigned m_cnt;
  logic [1:0]  obs_grant;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lsu_first = 1'b1;
    m_rw        = 1'b0;
    m_wr        = '0;
    m_wd        = '0;
    m_cnt       = 0;
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks everything.
  task automatic run_cycle(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                           input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                           input bit frz, input logic [4:0] r1, input logic [4:0] r2);
    bit exp_ar, exp_lr, both;
    logic [4:0]  rd;
    logic [31:0] dat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    freeze = frz; read_reg1 = r1; read_reg2 = r2;
    #1;
    both   = av && lv && !frz;
    exp_ar = both ? !m_lsu_first : (av && !frz);
    exp_lr = both ? m_lsu_first  : (lv && !frz);
    check("alu_ready", {31'b0, alu_ready}, {31'b0, exp_ar});
    check("lsu_ready", {31'b0, lsu_ready}, {31'b0, exp_lr});
    check("fwd1_hit", {31'b0, fwd1_hit}, {31'b0, m_rw && r1 == m_wr && m_wr != 0});
    check("fwd2_hit", {31'b0, fwd2_hit}, {31'b0, m_rw && r2 == m_wr && m_wr != 0});
    check("fwd1_data", fwd1_data, (m_rw && r1 == m_wr && m_wr != 0) ? m_wd : 32'h0);
    check("fwd2_data", fwd2_data, (m_rw && r2 == m_wr && m_wr != 0) ? m_wd : 32'h0);
    obs_grant = {lsu_ready, alu_ready};
    rd  = exp_ar ? ard  : lrd;
    dat = exp_ar ? adat : ldat;
    m_rw = (exp_ar || exp_lr) && rd != 0;
    if (m_rw) begin
      m_wr = rd;
      m_wd = dat;
    end
    if (both) begin
      m_lsu_first = !m_lsu_first;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
    @(posedge clk);
    #1;
    check("regwrite", {31'b0, regwrite}, {31'b0, m_rw});
    check("write_reg", {27'b0, write_reg}, {27'b0, m_wr});
    check("write_data", write_data, m_wd);
    check("conflict_cnt", {16'b0, conflict_cnt}, m_cnt);
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2;
    read_reg1 = '0; read_reg2 = '0;
    model_reset();
    #2;
    check("rst_regwrite", {31'b0, regwrite}, 32'h0);
    check("rst_write_reg", {27'b0, write_reg}, 32'h0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_cnt", {16'b0, conflict_cnt}, 32'h0);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'h0);
    check("rst_lsu_ready", {31'b0, lsu_ready}, 32'h0);
    check("rst_fwd1_hit", {31'b0, fwd1_hit}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ALU write, accepted on the first edge after reset release.
    run_cycle(1, 5'd3, 32'h1111, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("single_grant", {30'b0, obs_grant}, 32'h1);
    check("single_write_data", write_data, 32'h1111);

    // Four contended cycles: LSU first, then alternating.
    run_cycle(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0);
    check("rr_grant0", {30'b0, obs_grant}, 32'h2);
    run_cycle(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0);
    check("rr_grant1", {30'b0, obs_grant}, 32'h1);
    run_cycle(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0);
    check("rr_grant2", {30'b0, obs_grant}, 32'h2);
    run_cycle(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0);
    check("rr_grant3", {30'b0, obs_grant}, 32'h1);
    check("rr_cnt", {16'b0, conflict_cnt}, 32'd4);

    // r0 write: accepted, no regwrite, no bypass.
    run_cycle(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0);
    check("r0_grant", {30'b0, obs_grant}, 32'h2);
    check("r0_regwrite", {31'b0, regwrite}, 32'h0);

    // Bypass of an in-flight write.
    run_cycle(1, 5'd5, 32'h2222, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    run_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd5, 5'd6);
    check("fwd1_directed", fwd1_data, 32'h0);

    // Freeze with both valid, then release.
    run_cycle(1, 5'd5, 32'h2222, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    run_cycle(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, 5'd5, 5'd6);
    run_cycle(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 1, 5'd0, 5'd0);
    check("freeze_grant", {30'b0, obs_grant}, 32'h0);
    check("freeze_regwrite", {31'b0, regwrite}, 32'h0);
    run_cycle(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, 5'd0, 5'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      run_cycle($urandom_range(0, 1), 5'($urandom), $urandom,
                $urandom_range(0, 1), 5'($urandom), $urandom,
                ($urandom_range(0, 7) == 0), 5'($urandom), 5'($urandom));
    end

    // Asynchronous reset just after an acceptance, with a request pending.
    run_cycle(1, 5'd7, 32'hABCD, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("pre_rst_regwrite", {31'b0, regwrite}, 32'h1);
    alu_rd = 5'd9; alu_data = 32'h9999; read_reg1 = 5'd7;
    #1 rst_n = 1'b0;
    #1;
    check("arst_regwrite", {31'b0, regwrite}, 32'h0);
    check("arst_write_reg", {27'b0, write_reg}, 32'h0);
    check("arst_write_data", write_data, 32'h0);
    check("arst_cnt", {16'b0, conflict_cnt}, 32'h0);
    check("arst_alu_ready", {31'b0, alu_ready}, 32'h0);
    check("arst_fwd1_hit", {31'b0, fwd1_hit}, 32'h0);
    #1 rst_n = 1'b1;
    alu_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("post_rst_regwrite", {31'b0, regwrite}, 32'h0);

    // Drive the contention counter to saturation.
    while (m_cnt < 32'hFFFE) begin
      run_cycle(1, 5'($urandom), $urandom, 1, 5'($urandom), $urandom, 0, 5'd0, 5'd0);
    end
    check("cnt_fffe", {16'b0, conflict_cnt}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 5'd0, 5'd0);
    end
    check("cnt_sat", {16'b0, conflict_cnt}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
